spi_target_responder: RTL and testbench

SPI target (slave) responder for the Peripherals SPI subsystem. It sits at the far end of the SPI bus from the SPI controller that the `spi_if` UVC drives and monitors. It oversamples the bus pins on the system clock, deserialises controller MOSI frames into parallel bytes, and serialises a locally supplied transmit byte on MISO. It uses SPI mode 0 (CPOL=0, CPHA=0), MSB first, and a fixed frame length.

---
 rtl/spi_target_responder.sv | 181 ++++++++++++++++++
 tb/tb_spi_target_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_responder.sv
`default_nettype none
// ============================================================================
// Module  : spi_target_responder
// Brief   : SPI mode-0 target; oversampled pins, one-entry TX buffer, MSB first.
// Revision: 1.0 - initial release
// ============================================================================
module spi_target_responder #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_TX     = '1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int                 CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic                   buf_full;
    logic [DATA_WIDTH-1:0]  buf_data;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_word;
    logic [CNT_W-1:0]       bit_cnt;

    logic                   start, abort, do_rise, do_fall;
    logic                   load, underrun_next;
    logic [DATA_WIDTH-1:0]  load_word;

    // CS chain resets low so a CS held low through reset never looks like a new frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cs_rise takes priority over any SCLK edge seen in the same cycle.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        abort      = 1'b0;
        do_rise    = 1'b0;
        do_fall    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    do_rise = sclk_rise;
                    do_fall = sclk_fall;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load          = start | (do_fall & (bit_cnt == CNT_FULL));
    assign underrun_next = load & ~buf_full;
    assign load_word     = buf_full ? buf_data : IDLE_TX;
    assign rx_word       = {rx_shift, mosi_s};

    // Accept only into an empty buffer, so a same-cycle load never sees the new word.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            if (load && buf_full) begin
                buf_full <= 1'b0;
            end
            if (tx_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            miso_oe_o   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= underrun_next;
            if (start) begin
                tx_shift  <= load_word;
                bit_cnt   <= '0;
                miso_oe_o <= 1'b1;
            end else if (abort) begin
                bit_cnt   <= '0;
                miso_oe_o <= 1'b0;
            end else if (do_rise) begin
                rx_shift <= rx_word[DATA_WIDTH-2:0];
                if (bit_cnt != CNT_FULL) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                if (bit_cnt == CNT_LAST) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end
            end else if (do_fall) begin
                if (bit_cnt == CNT_FULL) begin
                    tx_shift <= load_word;
                    bit_cnt  <= '0;
                end else begin
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // MISO is the shifter MSB, held at 0 whenever the output is not enabled.
    assign miso_o   = miso_oe_o & tx_shift[DATA_WIDTH-1];
    assign tx_ready = ~buf_full;
    assign busy     = (state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_target_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_target_responder
// Brief   : Self-checking bench: vector table, corner sequences, random frames.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_target_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       miso_o, miso_oe_o, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;

    spi_target_responder #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2),
        .IDLE_TX    (8'hFF)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .sclk_i     (sclk),
        .cs_n_i     (cs_n),
        .mosi_i     (mosi),
        .miso_o     (miso_o),
        .miso_oe_o  (miso_oe_o),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_underrun(tx_underrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         und_cnt = 0;
    logic       rxv_prev = 1'b0;
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Received words and underrun pulses are collected as they happen.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            check("rx_valid_width", 32'(rxv_prev), 32'(0));
        end
        if (tx_underrun) und_cnt++;
        rxv_prev = rx_valid;
    end

    task automatic push_tx(input logic [7:0] d);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(tx_ready), 32'(1));
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] m, input bit do_push, input logic [7:0] pd,
                            output logic [7:0] got);
        for (int i = 7; i >= 0; i--) begin
            mosi = m[i];
            repeat (HALF) @(negedge clk);
            got[i] = miso_o;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            if (do_push && i == 4) push_tx(pd);
        end
    endtask

    task automatic run_frame(input logic [7:0] m, input bit do_push, input logic [7:0] pd,
                             output logic [7:0] got);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        check("oe_selected", 32'(miso_oe_o), 32'(1));
        check("busy_selected", 32'(busy), 32'(1));
        spi_byte(m, do_push, pd, got);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("oe_deselected", 32'(miso_oe_o), 32'(0));
        check("busy_deselected", 32'(busy), 32'(0));
    endtask

    task automatic expect_rx(input logic [7:0] exp);
        check("rx_count", 32'(rx_q.size()), 32'(1));
        if (rx_q.size() > 0) check("rx_data", 32'(rx_q.pop_front()), 32'(exp));
        rx_q = {};
    endtask

    typedef struct {
        bit         preload;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_und;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] got, got2;
    logic [7:0] model_buf[$];
    logic [7:0] exp_miso, tb_word, mid_word, mosi_word;
    int         base, exp_und, n;
    bit         pre, mid;

    initial begin
        // Each frame ends with one reload at the trailing SCLK fall; with an
        // empty buffer that reload is itself an underrun.
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
        vecs[1] = '{1'b0, 8'h00, 8'h81, 8'hFF, 8'h81, 2};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};
        vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h01, 1};

        repeat (4) @(negedge clk);
        check("rst_miso", 32'(miso_o), 32'(0));
        check("rst_oe", 32'(miso_oe_o), 32'(0));
        check("rst_tx_ready", 32'(tx_ready), 32'(1));
        check("rst_rx_data", 32'(rx_data), 32'(0));
        check("rst_rx_valid", 32'(rx_valid), 32'(0));
        check("rst_underrun", 32'(tx_underrun), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        repeat (6) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].preload) push_tx(vecs[v].tx);
            base = und_cnt;
            run_frame(vecs[v].mosi, 1'b0, 8'h00, got);
            check("vec_miso", 32'(got), 32'(vecs[v].exp_miso));
            expect_rx(vecs[v].exp_rx);
            check("vec_underruns", 32'(und_cnt - base), 32'(vecs[v].exp_und));
            check("vec_tx_ready", 32'(tx_ready), 32'(1));
        end

        // Back-to-back frames with CS held low and a push during frame 1.
        push_tx(8'h11);
        base = und_cnt;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'hF0, 1'b1, 8'h22, got);
        spi_byte(8'h0F, 1'b0, 8'h00, got2);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("b2b_miso1", 32'(got), 32'h11);
        check("b2b_miso2", 32'(got2), 32'h22);
        check("b2b_rx_count", 32'(rx_q.size()), 32'(2));
        if (rx_q.size() == 2) begin
            check("b2b_rx1", 32'(rx_q.pop_front()), 32'hF0);
            check("b2b_rx2", 32'(rx_q.pop_front()), 32'h0F);
        end
        rx_q = {};
        check("b2b_underruns", 32'(und_cnt - base), 32'(1));

        // CS abort after five bits.
        push_tx(8'h44);
        base = und_cnt;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_oe", 32'(miso_oe_o), 32'(0));
        check("abort_miso", 32'(miso_o), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        repeat (HALF) @(negedge clk);
        check("abort_no_rx", 32'(rx_q.size()), 32'(0));
        check("abort_underruns", 32'(und_cnt - base), 32'(0));
        base = und_cnt;
        run_frame(8'hC3, 1'b0, 8'h00, got);
        check("post_abort_miso", 32'(got), 32'hFF);
        expect_rx(8'hC3);
        check("post_abort_underruns", 32'(und_cnt - base), 32'(2));

        // One-cycle reset mid-frame with a word sitting in the TX buffer.
        push_tx(8'h33);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        push_tx(8'h66);
        check("mid_tx_ready", 32'(tx_ready), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        check("mrst_miso", 32'(miso_o), 32'(0));
        check("mrst_oe", 32'(miso_oe_o), 32'(0));
        check("mrst_tx_ready", 32'(tx_ready), 32'(1));
        check("mrst_rx_data", 32'(rx_data), 32'(0));
        check("mrst_rx_valid", 32'(rx_valid), 32'(0));
        check("mrst_underrun", 32'(tx_underrun), 32'(0));
        check("mrst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        check("mrst_no_rx", 32'(rx_q.size()), 32'(0));
        check("mrst_idle", 32'(busy), 32'(0));
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        base = und_cnt;
        run_frame(8'h5A, 1'b0, 8'h00, got);
        check("mrst_next_miso", 32'(got), 32'hFF);
        expect_rx(8'h5A);
        check("mrst_next_underruns", 32'(und_cnt - base), 32'(2));

        // tx_valid held with 0x77 then 0x99: only the first is taken until a load.
        base = und_cnt;
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        @(negedge clk);
        check("hs_ready_drop", 32'(tx_ready), 32'(0));
        tx_data = 8'h99;
        repeat (3) @(negedge clk);
        check("hs_ready_held_low", 32'(tx_ready), 32'(0));
        cs_n = 1'b0;
        n = 0;
        while (tx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hs_ready_after_load", 32'(tx_ready), 32'(1));
        @(negedge clk);
        tx_valid = 1'b0;
        check("hs_second_accept", 32'(tx_ready), 32'(0));
        spi_byte(8'hE7, 1'b0, 8'h00, got);
        spi_byte(8'h18, 1'b0, 8'h00, got2);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("hs_miso1", 32'(got), 32'h77);
        check("hs_miso2", 32'(got2), 32'h99);
        check("hs_rx_count", 32'(rx_q.size()), 32'(2));
        if (rx_q.size() == 2) begin
            check("hs_rx1", 32'(rx_q.pop_front()), 32'hE7);
            check("hs_rx2", 32'(rx_q.pop_front()), 32'h18);
        end
        rx_q = {};
        check("hs_underruns", 32'(und_cnt - base), 32'(1));

        // Random frames against a buffer model: each frame has two load points,
        // at CS fall and at the trailing SCLK fall.
        model_buf = {};
        for (int k = 0; k < 16; k++) begin
            pre       = 1'($urandom_range(0, 1));
            mid       = 1'($urandom_range(0, 1));
            tb_word   = 8'($urandom);
            mid_word  = 8'($urandom);
            mosi_word = 8'($urandom);
            exp_und   = 0;
            if (pre) begin
                push_tx(tb_word);
                model_buf.push_back(tb_word);
            end
            if (model_buf.size() > 0) begin
                exp_miso = model_buf.pop_front();
            end else begin
                exp_miso = 8'hFF;
                exp_und++;
            end
            if (mid) model_buf.push_back(mid_word);
            if (model_buf.size() > 0) void'(model_buf.pop_front());
            else exp_und++;
            base = und_cnt;
            run_frame(mosi_word, mid, mid_word, got);
            check("rnd_miso", 32'(got), 32'(exp_miso));
            expect_rx(mosi_word);
            check("rnd_underruns", 32'(und_cnt - base), 32'(exp_und));
            check("rnd_tx_ready", 32'(tx_ready), 32'(model_buf.size() == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
